// File: rtl/raster_timing_pkg.sv
// Raster timing generator shared definitions.
// Holds the timing-register index enum used on cfg_addr and the power-up
// timing values (a 384 x 289 raster) loaded into shadow and active copies
// on reset.
package raster_timing_pkg;

  typedef enum logic [3:0] {
    HTOTAL    = 4'd0,
    HBL_START = 4'd1,
    HBL_END   = 4'd2,
    HS_START  = 4'd3,
    HS_END    = 4'd4,
    VTOTAL    = 4'd5,
    VBL_START = 4'd6,
    VBL_END   = 4'd7,
    VS_START  = 4'd8,
    VS_END    = 4'd9
  } cfg_addr_e;

  localparam int unsigned DEF_HTOTAL    = 383;
  localparam int unsigned DEF_HBL_START = 256;
  localparam int unsigned DEF_HBL_END   = 0;
  localparam int unsigned DEF_HS_START  = 300;
  localparam int unsigned DEF_HS_END    = 332;
  localparam int unsigned DEF_VTOTAL    = 288;
  localparam int unsigned DEF_VBL_START = 241;
  localparam int unsigned DEF_VBL_END   = 17;
  localparam int unsigned DEF_VS_START  = 261;
  localparam int unsigned DEF_VS_END    = 269;

endpackage

// File: rtl/timing_window.sv
// Compare-set / compare-clear registered flag.
// On each enabled cycle the flag sets when pos equals set_at, otherwise
// clears when pos equals clr_at; set has priority when both match.
// Ports:
//   clk, reset    clock, synchronous active-high reset (flag -> 0)
//   ce            update enable
//   pos           current counter value
//   set_at        position that raises the flag
//   clr_at        position that lowers the flag
//   flag          registered window flag
module timing_window #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] pos,
  input  logic [W-1:0] set_at,
  input  logic [W-1:0] clr_at,
  output logic         flag
);

  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (ce) begin
      if (pos == set_at) begin
        flag <= 1'b1;
      end else if (pos == clr_at) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/raster_timing_gen.sv
// Programmable raster (video) timing generator.
// Horizontal/vertical counters advance on ce_pix; blanking and sync windows
// are compare-set/compare-clear flags. Timing registers are written into a
// shadow bank at any time and copied into the active bank on the pixel where
// the raster wraps to (0,0), so a frame never runs with mixed timing.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ce_pix              pixel enable; counters, flags and IRQ sets advance only here
//   cfg_we/addr/data    shadow timing register write (cfg_addr_e index)
//   hs_offset/vs_offset signed shift applied to the sync windows
//   hs_pol/vs_pol       1 = active-low sync outputs
//   irq_line, irq_en    raster IRQ line, enables {raster, vblank}
//   irq_ack             per-source sticky IRQ clear
//   hc, vc              current counters
//   hsync, vsync, hbl, vbl, de   timing outputs
//   frame_start         one-clock pulse after the wrap to (0,0)
//   irq                 sticky IRQ flags {raster, vblank}
module raster_timing_gen
  import raster_timing_pkg::*;
#(
  parameter int HW = 9,
  parameter int VW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  input  logic signed [3:0] hs_offset,
  input  logic signed [3:0] vs_offset,
  input  logic              hs_pol,
  input  logic              vs_pol,
  input  logic [VW-1:0]     irq_line,
  input  logic [1:0]        irq_en,
  input  logic [1:0]        irq_ack,
  output logic [HW-1:0]     hc,
  output logic [VW-1:0]     vc,
  output logic              hsync,
  output logic              vsync,
  output logic              hbl,
  output logic              vbl,
  output logic              de,
  output logic              frame_start,
  output logic [1:0]        irq
);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic [HW-1:0] sh_htotal, sh_hbl_start, sh_hbl_end, sh_hs_start, sh_hs_end;
  logic [VW-1:0] sh_vtotal, sh_vbl_start, sh_vbl_end, sh_vs_start, sh_vs_end;
  logic [HW-1:0] act_htotal, act_hbl_start, act_hbl_end, act_hs_start, act_hs_end;
  logic [VW-1:0] act_vtotal, act_vbl_start, act_vbl_end, act_vs_start, act_vs_end;

  logic          h_end, v_end, frame_wrap;
  logic [HW-1:0] hs_set, hs_clr;
  logic [VW-1:0] vs_set, vs_clr;
  logic          hs_flag, vs_flag;
  logic [1:0]    irq_set;
  logic          unused_cfg_bits;

  // Sync window edge shifted by a sign-extended offset, wrapping modulo 2^W.
  function automatic logic [HW-1:0] shift_h(input logic [HW-1:0] base,
                                            input logic signed [3:0] ofs);
    logic signed [HW-1:0] ext;
    ext = {{(HW-4){ofs[3]}}, ofs};
    return base + $unsigned(ext);
  endfunction

  function automatic logic [VW-1:0] shift_v(input logic [VW-1:0] base,
                                            input logic signed [3:0] ofs);
    logic signed [VW-1:0] ext;
    ext = {{(VW-4){ofs[3]}}, ofs};
    return base + $unsigned(ext);
  endfunction

  // Only the low HW/VW bits of cfg_data are meaningful.
  assign unused_cfg_bits = ^cfg_data;

  // >= rather than == so a total reprogrammed below the live count still wraps.
  assign h_end      = (h >= act_htotal);
  assign v_end      = (v >= act_vtotal);
  assign frame_wrap = ce_pix && h_end && v_end;

  // Shadow bank: written on any clock, independent of ce_pix.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_htotal    <= HW'(DEF_HTOTAL);
      sh_hbl_start <= HW'(DEF_HBL_START);
      sh_hbl_end   <= HW'(DEF_HBL_END);
      sh_hs_start  <= HW'(DEF_HS_START);
      sh_hs_end    <= HW'(DEF_HS_END);
      sh_vtotal    <= VW'(DEF_VTOTAL);
      sh_vbl_start <= VW'(DEF_VBL_START);
      sh_vbl_end   <= VW'(DEF_VBL_END);
      sh_vs_start  <= VW'(DEF_VS_START);
      sh_vs_end    <= VW'(DEF_VS_END);
    end else if (cfg_we) begin
      case (cfg_addr)
        HTOTAL:    sh_htotal    <= cfg_data[HW-1:0];
        HBL_START: sh_hbl_start <= cfg_data[HW-1:0];
        HBL_END:   sh_hbl_end   <= cfg_data[HW-1:0];
        HS_START:  sh_hs_start  <= cfg_data[HW-1:0];
        HS_END:    sh_hs_end    <= cfg_data[HW-1:0];
        VTOTAL:    sh_vtotal    <= cfg_data[VW-1:0];
        VBL_START: sh_vbl_start <= cfg_data[VW-1:0];
        VBL_END:   sh_vbl_end   <= cfg_data[VW-1:0];
        VS_START:  sh_vs_start  <= cfg_data[VW-1:0];
        VS_END:    sh_vs_end    <= cfg_data[VW-1:0];
        default: ;
      endcase
    end
  end

  // Active bank: copies the pre-edge shadow, so a write on the wrap clock
  // lands in the shadow only and applies one frame later.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_htotal    <= HW'(DEF_HTOTAL);
      act_hbl_start <= HW'(DEF_HBL_START);
      act_hbl_end   <= HW'(DEF_HBL_END);
      act_hs_start  <= HW'(DEF_HS_START);
      act_hs_end    <= HW'(DEF_HS_END);
      act_vtotal    <= VW'(DEF_VTOTAL);
      act_vbl_start <= VW'(DEF_VBL_START);
      act_vbl_end   <= VW'(DEF_VBL_END);
      act_vs_start  <= VW'(DEF_VS_START);
      act_vs_end    <= VW'(DEF_VS_END);
    end else if (frame_wrap) begin
      act_htotal    <= sh_htotal;
      act_hbl_start <= sh_hbl_start;
      act_hbl_end   <= sh_hbl_end;
      act_hs_start  <= sh_hs_start;
      act_hs_end    <= sh_hs_end;
      act_vtotal    <= sh_vtotal;
      act_vbl_start <= sh_vbl_start;
      act_vbl_end   <= sh_vbl_end;
      act_vs_start  <= sh_vs_start;
      act_vs_end    <= sh_vs_end;
    end
  end

  // Raster counters and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (ce_pix) begin
        if (h_end) begin
          h <= '0;
          v <= v_end ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign hc = h;
  assign vc = v;

  assign hs_set = shift_h(act_hs_start, hs_offset);
  assign hs_clr = shift_h(act_hs_end,   hs_offset);
  assign vs_set = shift_v(act_vs_start, vs_offset);
  assign vs_clr = shift_v(act_vs_end,   vs_offset);

  // Vertical windows compare on every pixel, not only at line wrap, so
  // they change one clock after the first pixel of the matching line.
  timing_window #(.W(HW)) u_hbl (
    .clk(clk), .reset(reset), .ce(ce_pix), .pos(h),
    .set_at(act_hbl_start), .clr_at(act_hbl_end), .flag(hbl)
  );

  timing_window #(.W(HW)) u_hsync (
    .clk(clk), .reset(reset), .ce(ce_pix), .pos(h),
    .set_at(hs_set), .clr_at(hs_clr), .flag(hs_flag)
  );

  timing_window #(.W(VW)) u_vbl (
    .clk(clk), .reset(reset), .ce(ce_pix), .pos(v),
    .set_at(act_vbl_start), .clr_at(act_vbl_end), .flag(vbl)
  );

  timing_window #(.W(VW)) u_vsync (
    .clk(clk), .reset(reset), .ce(ce_pix), .pos(v),
    .set_at(vs_set), .clr_at(vs_clr), .flag(vs_flag)
  );

  assign hsync = hs_flag ^ hs_pol;
  assign vsync = vs_flag ^ vs_pol;
  assign de    = !hbl && !vbl;

  // Sticky interrupts: a set on the same clock as its ack wins.
  assign irq_set[0] = ce_pix && irq_en[0] && (h == '0) && (v == act_vbl_start);
  assign irq_set[1] = ce_pix && irq_en[1] && (h == act_hbl_start) && (v == irq_line);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 2'b00;
    end else begin
      irq <= irq_set | (irq & ~irq_ack);
    end
  end

endmodule
